// File: rtl/mem_bus_bridge.sv
// mem_bus_bridge: turns the core's held memory strobes into a valid/ready bus request and an rvalid response.
// Latency: misaligned 1 cycle, store 2 cycles, read 3 cycles at zero wait; each bus wait cycle adds one.
// Backpressure: bus_valid and payload stay stable until bus_ready; core_stall holds the core until core_done.
// Optional feature: define MEM_BUS_BRIDGE_TIMEOUT_EN to abort a phase after TIMEOUT wait cycles.
module mem_bus_bridge #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        core_req,
  input  logic        core_we,
  input  logic        core_ifetch,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  input  logic [2:0]  core_funct3,
  output logic        core_stall,
  output logic        core_done,
  output logic        core_err,
  output logic [31:0] instr,
  output logic [31:0] rdata,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  // FSM decode outputs
  logic        w_accept;       // aligned request taken in IDLE
  logic        w_err_nxt;      // the transition into DONE carries an error
  logic        w_capture;      // read word arrives in RESP
  logic        w_misaligned;
  logic        w_timeout_hit;

  // Store lane steering (from live core inputs, latched on accept)
  logic [3:0]  w_lane_wstrb;
  logic [31:0] w_lane_wdata;

  // Load extension (from latched size/offset and live bus data)
  logic [7:0]  w_sel_byte;
  logic [15:0] w_sel_half;
  logic [31:0] w_load_ext;

  // Registered outputs and latched access attributes
  logic        r_bus_valid;
  logic        r_bus_we;
  logic [31:0] r_bus_addr;
  logic [31:0] r_bus_wdata;
  logic [3:0]  r_bus_wstrb;
  logic        r_err;
  logic [31:0] r_instr;
  logic [31:0] r_rdata;
  logic [2:0]  r_funct3;
  logic [1:0]  r_addr_lo;
  logic        r_ifetch;

  // Halfword accesses need an even address, words need a 4-byte aligned one;
  // only the exact word encoding is checked, bytes are always legal.
  assign w_misaligned = ((core_funct3[1:0] == 2'b01) && core_addr[0]) ||
                        ((core_funct3 == 3'b010) && (core_addr[1:0] != 2'b00));

  // Replicate store data across all lanes and enable only the addressed bytes.
  always_comb begin
    w_lane_wstrb = 4'b1111;
    w_lane_wdata = core_wdata;
    case (core_funct3[1:0])
      2'b00: begin
        w_lane_wstrb = 4'b0001 << core_addr[1:0];
        w_lane_wdata = {4{core_wdata[7:0]}};
      end
      2'b01: begin
        w_lane_wstrb = 4'b0011 << core_addr[1:0];
        w_lane_wdata = {2{core_wdata[15:0]}};
      end
      default: begin
        w_lane_wstrb = 4'b1111;
        w_lane_wdata = core_wdata;
      end
    endcase
  end

  // Pick the addressed byte/half out of the returned word and extend it.
  always_comb begin
    w_sel_byte = bus_rdata[{r_addr_lo, 3'b000} +: 8];
    w_sel_half = r_addr_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    w_load_ext = bus_rdata;
    case (r_funct3)
      3'b000:  w_load_ext = {{24{w_sel_byte[7]}}, w_sel_byte};
      3'b001:  w_load_ext = {{16{w_sel_half[15]}}, w_sel_half};
      3'b100:  w_load_ext = {24'h000000, w_sel_byte};
      3'b101:  w_load_ext = {16'h0000, w_sel_half};
      default: w_load_ext = bus_rdata;
    endcase
  end

`ifdef MEM_BUS_BRIDGE_TIMEOUT_EN
  logic [7:0] r_wait_cnt;

  // Count cycles spent waiting in the current bus phase; any state change restarts it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wait_cnt <= 8'd0;
    end else if (w_state_nxt != r_state) begin
      r_wait_cnt <= 8'd0;
    end else if ((r_state == S_REQ) || (r_state == S_RESP)) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end

  // The current cycle is the TIMEOUT-th wait cycle of this phase; the FSM
  // lets a same-cycle ready/rvalid win over the abort.
  assign w_timeout_hit = ((r_state == S_REQ) || (r_state == S_RESP)) &&
                         (r_wait_cnt == 8'(TIMEOUT - 1));
`else
  logic [7:0] w_unused_timeout;

  assign w_unused_timeout = 8'(TIMEOUT);
  assign w_timeout_hit    = 1'b0;
`endif

  // Current state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-transition strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_err_nxt   = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (core_req) begin
          if (w_misaligned) begin
            w_state_nxt = S_DONE;
            w_err_nxt   = 1'b1;
          end else begin
            w_state_nxt = S_REQ;
            w_accept    = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (bus_ready) begin
          w_state_nxt = r_bus_we ? S_DONE : S_RESP;
        end else if (w_timeout_hit) begin
          w_state_nxt = S_DONE;
          w_err_nxt   = 1'b1;
        end
      end
      S_RESP: begin
        if (bus_rvalid) begin
          w_state_nxt = S_DONE;
          w_capture   = 1'b1;
        end else if (w_timeout_hit) begin
          w_state_nxt = S_DONE;
          w_err_nxt   = 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Latch the access on acceptance, drive the bus, and capture returned data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bus_valid <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= 32'h0000_0000;
      r_bus_wdata <= 32'h0000_0000;
      r_bus_wstrb <= 4'b0000;
      r_err       <= 1'b0;
      r_instr     <= 32'h0000_0013;
      r_rdata     <= 32'h0000_0000;
      r_funct3    <= 3'b000;
      r_addr_lo   <= 2'b00;
      r_ifetch    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_bus_we    <= core_we;
        r_bus_addr  <= {core_addr[31:2], 2'b00};
        r_bus_wdata <= w_lane_wdata;
        r_bus_wstrb <= core_we ? w_lane_wstrb : 4'b0000;
        r_funct3    <= core_funct3;
        r_addr_lo   <= core_addr[1:0];
        r_ifetch    <= core_ifetch;
      end
      // Valid tracks residency in REQ, so it drops on ready or on abort.
      r_bus_valid <= (w_state_nxt == S_REQ);
      r_err       <= (w_state_nxt == S_DONE) && w_err_nxt;
      if (w_capture) begin
        if (r_ifetch) begin
          r_instr <= bus_rdata;
        end else begin
          r_rdata <= w_load_ext;
        end
      end
    end
  end

  assign core_done  = (r_state == S_DONE);
  assign core_err   = r_err;
  assign core_stall = core_req & ~core_done;
  assign instr      = r_instr;
  assign rdata      = r_rdata;
  assign bus_valid  = r_bus_valid;
  assign bus_we     = r_bus_we;
  assign bus_addr   = r_bus_addr;
  assign bus_wdata  = r_bus_wdata;
  assign bus_wstrb  = r_bus_wstrb;

endmodule

// File: tb/tb_mem_bus_bridge.sv
// tb_mem_bus_bridge: bench for mem_bus_bridge with a timeline/arithmetic reference model.
// Each access is predicted as a schedule (valid window, done cycle) plus the resulting registers.
// A per-cycle checker compares every visible output against that prediction.
module tb_mem_bus_bridge;

`ifdef MEM_BUS_BRIDGE_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 1000;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        core_req = 1'b0;
  logic        core_we = 1'b0;
  logic        core_ifetch = 1'b0;
  logic [31:0] core_addr = 32'h0;
  logic [31:0] core_wdata = 32'h0;
  logic [2:0]  core_funct3 = 3'd0;
  logic        core_stall, core_done, core_err;
  logic [31:0] instr, rdata;
  logic        bus_valid, bus_we;
  logic        bus_ready = 1'b0;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;

  mem_bus_bridge #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_ifetch(core_ifetch),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_funct3(core_funct3),
    .core_stall(core_stall), .core_done(core_done), .core_err(core_err),
    .instr(instr), .rdata(rdata),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected schedule and results of the access in flight
  int          t_n = -10, t_rdy = -100, t_val = -100, t_bv_end = -10, t_done = -10;
  logic        e_mis = 1'b0, e_err = 1'b0, e_we = 1'b0;
  logic [31:0] e_addr = 32'h0, e_wdata = 32'h0, t_word = 32'h0;
  logic [3:0]  e_wstrb = 4'h0;
  logic [31:0] m_instr = 32'h13, e_instr = 32'h13, m_rdata = 32'h0, e_rdata = 32'h0;
  bit          chk_on = 1'b0;

  // Observations of the DUT taken by the checker
  int          cap_done = -1;
  logic        cap_err = 1'b0, saw_bv = 1'b0;
  logic [31:0] cap_addr = 32'h0, cap_wdata = 32'h0;
  logic [3:0]  cap_wstrb = 4'h0;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h, want %h", name, cyc, act, exp);
    end
  endtask

  // Bus responder: the scheduled ready/rvalid pulses, plus random pulses
  // only where the bridge must ignore them.
  always @(posedge clk) begin
    #2;
    bus_ready  = (cyc == t_rdy) ||
                 (($urandom_range(0, 3) == 0) && !(cyc > t_n && cyc <= t_rdy));
    bus_rvalid = (cyc == t_val) ||
                 (($urandom_range(0, 3) == 0) && !(cyc > t_rdy && cyc <= t_val));
    bus_rdata  = (cyc == t_val) ? t_word : $urandom;
  end

  logic dn, bv;
  // Per-cycle compare of every output against the predicted schedule.
  always @(negedge clk) begin
    if (chk_on) begin
      dn = (cyc == t_done);
      bv = !e_mis && (cyc > t_n) && (cyc <= t_bv_end);
      chk("core_done", core_done, dn);
      chk("core_stall", core_stall, core_req & ~dn);
      if (dn) chk("core_err", core_err, e_err);
      chk("bus_valid", bus_valid, bv);
      if (bv) begin
        chk("bus_addr", bus_addr, e_addr);
        chk("bus_we", bus_we, e_we);
        chk("bus_wstrb", bus_wstrb, e_wstrb);
        if (e_we) chk("bus_wdata", bus_wdata, e_wdata);
        cap_addr  = bus_addr;
        cap_wdata = bus_wdata;
        cap_wstrb = bus_wstrb;
      end
      if (bus_valid) saw_bv = 1'b1;
      if (core_done && cap_done < 0) begin
        cap_done = cyc;
        cap_err  = core_err;
      end
      chk("instr", instr, (cyc >= t_done) ? e_instr : m_instr);
      chk("rdata", rdata, (cyc >= t_done) ? e_rdata : m_rdata);
    end
  end

  // Predict one access from the architectural rules, then drive it.
  // Called just after a rising edge; returns just after the edge following core_done.
  task automatic do_txn(input logic we, input logic ifetch, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3,
                        input logic [31:0] word, input int rw, input int vw);
    int nb;
    logic [31:0] sh, v;
    t_n    = cyc;
    e_mis  = ((f3 == 3'd1 || f3 == 3'd5) && addr[0]) || (f3 == 3'd2 && addr[1:0] != 2'd0);
    e_we   = we;
    e_addr = addr & 32'hFFFF_FFFC;
    nb     = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    e_wstrb = !we ? 4'h0 : (nb == 4) ? 4'hF : 4'(((1 << nb) - 1) << addr[1:0]);
    e_wdata = (nb == 1) ? 32'(wdata[7:0]) * 32'h0101_0101 :
              (nb == 2) ? 32'(wdata[15:0]) * 32'h0001_0001 : wdata;
    sh = word >> (8 * addr[1:0]);
    case (f3)
      3'd0:    v = (sh & 32'hFF) | (((sh & 32'h80) != 0) ? 32'hFFFF_FF00 : 32'h0);
      3'd1:    v = (sh & 32'hFFFF) | (((sh & 32'h8000) != 0) ? 32'hFFFF_0000 : 32'h0);
      3'd4:    v = sh & 32'hFF;
      3'd5:    v = sh & 32'hFFFF;
      default: v = word;
    endcase
    e_instr = m_instr;
    e_rdata = m_rdata;
    e_err   = 1'b0;
    t_rdy = -100; t_val = -100; t_bv_end = -10; t_word = word;
    if (e_mis) begin
      t_done = t_n + 1;
      e_err  = 1'b1;
    end else if (rw >= TO) begin
      t_rdy    = t_n + 1 + rw;
      t_bv_end = t_n + TO;
      t_done   = t_n + 1 + TO;
      e_err    = 1'b1;
    end else begin
      t_rdy    = t_n + 1 + rw;
      t_bv_end = t_rdy;
      if (we) begin
        t_done = t_rdy + 1;
      end else begin
        t_val = t_rdy + 1 + vw;
        if (vw >= TO) begin
          t_done = t_rdy + 1 + TO;
          e_err  = 1'b1;
        end else begin
          t_done = t_val + 1;
          if (ifetch) e_instr = word;
          else        e_rdata = v;
        end
      end
    end
    saw_bv = 1'b0; cap_done = -1; cap_err = 1'b0;
    core_req = 1'b1; core_we = we; core_ifetch = ifetch;
    core_addr = addr; core_wdata = wdata; core_funct3 = f3;
    while (cyc < t_done) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    core_req = 1'b0; core_addr = $urandom; core_wdata = $urandom;
    m_instr = e_instr;
    m_rdata = e_rdata;
  endtask

  logic        r_we_s, r_fe_s;
  logic [2:0]  r_f3_s;
  logic [31:0] r_addr_s;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bus_valid", bus_valid, 32'd0);
    chk("rst_bus_we", bus_we, 32'd0);
    chk("rst_core_done", core_done, 32'd0);
    chk("rst_core_err", core_err, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_bus_wstrb", bus_wstrb, 32'd0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_rdata", rdata, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk_on = 1'b1;

    do_txn(0, 0, 32'h100, 32'h0, 3'd2, 32'h8000_00FF, 0, 0);
    chk("lw_rdata", rdata, 32'h8000_00FF);
    chk("lw_latency", cap_done - t_n, 32'd3);
    chk("lw_err", cap_err, 32'd0);
    chk("lw_instr", instr, 32'h0000_0013);
    do_txn(0, 0, 32'h103, 32'h0, 3'd0, 32'h80FF_1234, 1, 1);
    chk("lb_rdata", rdata, 32'hFFFF_FF80);
    do_txn(0, 0, 32'h103, 32'h0, 3'd4, 32'h80FF_1234, 0, 2);
    chk("lbu_rdata", rdata, 32'h0000_0080);
    do_txn(0, 0, 32'h102, 32'h0, 3'd5, 32'h80FF_1234, 2, 0);
    chk("lhu_rdata", rdata, 32'h0000_80FF);
    do_txn(1, 0, 32'h206, 32'h0000_ABCD, 3'd1, 32'h0, 3, 0);
    chk("sh_addr", cap_addr, 32'h204);
    chk("sh_wstrb", cap_wstrb, 32'hC);
    chk("sh_wdata", cap_wdata, 32'hABCD_ABCD);
    chk("sh_latency", cap_done - t_n, 32'd5);
    do_txn(0, 0, 32'h101, 32'h0, 3'd2, 32'h1111_1111, 0, 0);
    chk("mis_err", cap_err, 32'd1);
    chk("mis_latency", cap_done - t_n, 32'd1);
    chk("mis_no_valid", saw_bv, 32'd0);
    chk("mis_rdata", rdata, 32'h0000_80FF);
    do_txn(0, 1, 32'h0, 32'h0, 3'd2, 32'hDEAD_BEEF, 1, 2);
    chk("fetch_instr", instr, 32'hDEAD_BEEF);
    chk("fetch_latency", cap_done - t_n, 32'd6);

    // Reset while a fetch waits in RESP: abandon it without core_done.
    chk_on = 1'b0;
    t_n = cyc; t_rdy = cyc + 1; t_bv_end = cyc + 1; t_val = cyc + 200; t_done = cyc + 500;
    core_req = 1'b1; core_we = 1'b0; core_ifetch = 1'b1; core_addr = 32'h300; core_funct3 = 3'd2;
    repeat (3) begin @(posedge clk); #1; end
    #1 reset = 1'b0;
    #1;
    chk("rstmid_bus_valid", bus_valid, 32'd0);
    chk("rstmid_instr", instr, 32'h0000_0013);
    chk("rstmid_done", core_done, 32'd0);
    chk("rstmid_rdata", rdata, 32'd0);
    core_req = 1'b0;
    t_n = -10; t_rdy = -100; t_val = -100; t_bv_end = -10; t_done = -10;
    m_instr = 32'h13; e_instr = 32'h13; m_rdata = 32'h0; e_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    chk_on = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    do_txn(0, 1, 32'h10, 32'h0, 3'd2, 32'h0010_0093, 0, 3);
    chk("refetch_instr", instr, 32'h0010_0093);
    chk("refetch_latency", cap_done - t_n, 32'd6);

`ifdef MEM_BUS_BRIDGE_TIMEOUT_EN
    do_txn(1, 0, 32'h400, 32'h1122_3344, 3'd2, 32'h0, 10, 0);
    chk("to_store_err", cap_err, 32'd1);
    chk("to_store_latency", cap_done - t_n, 32'd5);
    do_txn(0, 0, 32'h404, 32'h0, 3'd2, 32'h5555_AAAA, 0, 10);
    chk("to_read_err", cap_err, 32'd1);
    chk("to_read_rdata", rdata, 32'd0);
    repeat (8) begin @(posedge clk); #1; end
    chk("to_read_late", rdata, 32'd0);
`endif

    for (int i = 0; i < 200; i++) begin
      r_we_s   = 1'($urandom_range(0, 1));
      r_fe_s   = !r_we_s && ($urandom_range(0, 2) == 0);
      r_f3_s   = r_we_s ? 3'($urandom_range(0, 2)) : r_fe_s ? 3'd2 : 3'($urandom_range(0, 7));
      r_addr_s = $urandom;
      if ($urandom_range(0, 1) == 0) r_addr_s[1:0] = 2'b00;
      do_txn(r_we_s, r_fe_s, r_addr_s, $urandom, r_f3_s, $urandom,
             int'($urandom_range(0, 5)), int'($urandom_range(0, 5)));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
